heart_sample_scaler: RTL and testbench



---
 rtl/heart_pkg.sv | 9 +
 rtl/heart_lzc.sv | 13 +
 rtl/heart_sample_scaler.sv | 124 ++++++++++++
 tb/tb_heart_sample_scaler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/heart_pkg.sv
// Shared widths and FSM encoding for the heart sample scaler.
package heart_pkg;
    localparam int SAMPLE_W = 32;
    localparam int SPAN_W   = 33;
    localparam int SHIFT_W  = 6;
    localparam int DROP_W   = 16;

    typedef enum logic {ST_CAL, ST_RUN} state_t;
endpackage

// File: rtl/heart_lzc.sv
// Bit length of a 33-bit span: index of the highest set bit plus one, 0 for zero.
module heart_lzc
    import heart_pkg::*;
(
    input  logic [SPAN_W-1:0]  span,
    output logic [SHIFT_W-1:0] len
);
    always_comb begin
        len = '0;
        for (int i = 0; i < SPAN_W; i++)
            if (span[i]) len = SHIFT_W'(i + 1);
    end
endmodule

// File: rtl/heart_sample_scaler.sv
// Decimate, window min/max, and auto-scale heart samples to unsigned OUT_W-bit codes.
module heart_sample_scaler
    import heart_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int WIN   = 256,
    parameter int OUT_W = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] heart_in,
    input  logic                       heart_valid,
    output logic [OUT_W-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       cal_done,
    output logic [SHIFT_W-1:0]         shift_out,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);
    // Counters are 16 bits wide, so DECIM and WIN are limited to 65536.
    localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);
    localparam logic [15:0] WIN_LAST   = 16'(WIN - 1);
    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SPAN_W-1:0]  CODE_MAX = SPAN_W'((64'd1 << OUT_W) - 1);
    localparam logic [SHIFT_W-1:0] OUT_W_S  = SHIFT_W'(OUT_W);

    state_t                      state;
    logic [15:0]                 dcnt, wcnt;
    logic signed [SAMPLE_W-1:0]  acc_min, acc_max, ref_min, ref_max;
    logic                        keep, win_end;
    logic signed [SAMPLE_W-1:0]  nxt_min, nxt_max;
    logic [SPAN_W-1:0]           nxt_span;
    logic [SHIFT_W-1:0]          nxt_len, nxt_shift;
    logic                        s1_valid;
    logic signed [SAMPLE_W-1:0]  s1_x;
    logic [SPAN_W-1:0]           diff, scaled;
    logic [OUT_W-1:0]            code;

    assign keep     = heart_valid && (dcnt == DECIM_LAST);
    assign win_end  = keep && (wcnt == WIN_LAST);
    assign nxt_min  = (heart_in < acc_min) ? heart_in : acc_min;
    assign nxt_max  = (heart_in > acc_max) ? heart_in : acc_max;
    assign nxt_span = {nxt_max[SAMPLE_W-1], nxt_max} - {nxt_min[SAMPLE_W-1], nxt_min};

    heart_lzc u_lzc (
        .span (nxt_span),
        .len  (nxt_len)
    );

    assign nxt_shift = (nxt_len > OUT_W_S) ? nxt_len - OUT_W_S : '0;

    // S2 scales against whatever refs are registered now, so a window's
    // final sample is already coded with that window's own refs.
    assign diff   = {s1_x[SAMPLE_W-1], s1_x} - {ref_min[SAMPLE_W-1], ref_min};
    assign scaled = diff >> shift_out;

    always_comb begin
        code = '0;
        if (diff[SPAN_W-1])
            code = '0;
        else if (ref_max == ref_min)
            code = (diff == '0) ? '0 : '1;
        else if (scaled > CODE_MAX)
            code = '1;
        else
            code = scaled[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CAL;
            dcnt       <= '0;
            wcnt       <= '0;
            acc_min    <= S_MAX;
            acc_max    <= S_MIN;
            ref_min    <= '0;
            ref_max    <= '0;
            shift_out  <= '0;
            cal_done   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_x       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            s1_valid <= keep && (state == ST_RUN);
            if (keep) s1_x <= heart_in;
            if (heart_valid) dcnt <= (dcnt == DECIM_LAST) ? '0 : dcnt + 1'b1;

            if (keep) begin
                if (win_end) begin
                    wcnt      <= '0;
                    acc_min   <= S_MAX;
                    acc_max   <= S_MIN;
                    ref_min   <= nxt_min;
                    ref_max   <= nxt_max;
                    shift_out <= nxt_shift;
                    cal_done  <= 1'b1;
                    state     <= ST_RUN;
                end else begin
                    wcnt    <= wcnt + 1'b1;
                    acc_min <= nxt_min;
                    acc_max <= nxt_max;
                end
            end

            // An accept frees the slot in the same cycle a new code lands.
            if (s1_valid) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= code;
                    dout_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_heart_sample_scaler.sv
// Bench for heart_sample_scaler: table vectors plus hand sequences, codes scored through a queue.
module tb_heart_sample_scaler;
    localparam int DECIM = 4;
    localparam int WIN   = 8;
    localparam int OUT_W = 12;
    localparam longint CMAX = (64'sd1 << OUT_W) - 1;

    logic               clk = 1'b0;
    logic               reset, heart_valid, dout_ready;
    logic signed [31:0] heart_in;
    logic [OUT_W-1:0]   dout;
    logic               dout_valid, cal_done, overflow;
    logic [5:0]         shift_out;
    logic [15:0]        drop_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int     mdcnt, mwcnt, msh;
    longint amin, amax, rmin, rmax;
    bit     mrun, sb_on, ovr;
    int     ovr_code;
    int     q[$];

    typedef struct { int x; int code; } vec_t;
    vec_t tab[6];

    always #5 clk = ~clk;

    heart_sample_scaler #(.DECIM(DECIM), .WIN(WIN), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .heart_in(heart_in), .heart_valid(heart_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .cal_done(cal_done), .shift_out(shift_out), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int calc_shift(input longint span);
        int l = 0;
        while (l < 63 && (span >> l) != 0) l++;
        return (l > OUT_W) ? l - OUT_W : 0;
    endfunction

    function automatic int exp_code(input longint x);
        longint d = x - rmin;
        longint c;
        if (d < 0) return 0;
        if (rmax == rmin) return (d > 0) ? int'(CMAX) : 0;
        c = d >>> msh;
        return (c > CMAX) ? int'(CMAX) : int'(c);
    endfunction

    task automatic model_reset();
        mdcnt = 0; mwcnt = 0; msh = 0; mrun = 1'b0;
        amin = 64'sd2147483647; amax = -64'sd2147483648;
        rmin = 0; rmax = 0;
        q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One clock of input; the model sees exactly what the DUT samples.
    task automatic feed(input int x, input bit vld = 1'b1);
        bit was_run;
        heart_in = x;
        heart_valid = vld;
        @(posedge clk);
        if (vld) begin
            if (mdcnt == DECIM - 1) begin
                mdcnt = 0;
                was_run = mrun;
                if (x < amin) amin = x;
                if (x > amax) amax = x;
                if (mwcnt == WIN - 1) begin
                    rmin = amin; rmax = amax; msh = calc_shift(rmax - rmin);
                    amin = 64'sd2147483647; amax = -64'sd2147483648;
                    mwcnt = 0; mrun = 1'b1;
                end else mwcnt++;
                if (was_run && sb_on) q.push_back(ovr ? ovr_code : exp_code(x));
            end else mdcnt++;
        end
        #1;
        heart_valid = 1'b0;
    endtask

    // Three discarded fillers far outside any window, then the kept sample.
    task automatic keep_one(input int x);
        for (int j = 0; j < DECIM - 1; j++) feed((j == 1) ? -7000000 : 7000000);
        feed(x);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_cal_done"}, cal_done, 0);
        chk({tag, "_shift"}, shift_out, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    // Window of span -1000..2000 (span 3000, 12 bits -> shift 0).
    task automatic cal_window(input string tag);
        int w1[8] = '{-1000, 2000, 5, -7, 300, 1999, -999, 0};
        bit seen = 1'b0;
        bit early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < DECIM - 1; j++) begin
                feed((j == 1) ? -7000000 : 7000000);
                seen |= dout_valid; early |= cal_done;
            end
            feed(w1[i]);
            seen |= dout_valid;
            if (i < 7) early |= cal_done;
        end
        chk({tag, "_no_out"}, seen, 0);
        chk({tag, "_cal_early"}, early, 0);
        chk({tag, "_cal_done"}, cal_done, 1);
        chk({tag, "_shift"}, shift_out, 0);
    endtask

    always @(negedge clk) begin
        if (sb_on && !reset && dout_valid && dout_ready) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected: got dout=%0d expected no code", dout);
            end else begin
                chk("sb_dout", dout, q.pop_front());
            end
        end
    end

    initial begin
        int vc;
        tab[0] = '{-244000, 1000};
        tab[1] = '{ 600000, 4095};
        tab[2] = '{-600000,    0};
        tab[3] = '{-500000,    0};
        tab[4] = '{ 500000, 3906};
        tab[5] = '{      0, 1953};

        reset = 1'b1; heart_valid = 1'b0; heart_in = 0; dout_ready = 1'b1;
        sb_on = 1'b1; ovr = 1'b0; ovr_code = 0;
        model_reset();
        step(2);
        reset = 1'b0;
        step(1);
        chk_reset("rst");

        cal_window("w1");

        // Latency: kept at t, dout_valid visible at t+2.
        keep_one(500);
        chk("lat_t1_valid", dout_valid, 0);
        step(1);
        chk("lat_t2_valid", dout_valid, 1);
        chk("lat_t2_dout", dout, 1500);

        // Window 2 spans -500000..500000 -> 20 bits -> shift 8.
        keep_one(-500000); keep_one(500000); keep_one(1000); keep_one(-2000);
        keep_one(3000); keep_one(10000); keep_one(-100);
        chk("w2_shift", shift_out, 8);
        step(3);

        for (int i = 0; i < 6; i++) begin
            ovr = 1'b1; ovr_code = tab[i].code;
            keep_one(tab[i].x);
            ovr = 1'b0;
        end
        step(3);
        chk("tab_drain", q.size(), 0);

        // Back-pressure: A (600000>>8=2343) held, B dropped; B also closes window 3 (shift 9).
        sb_on = 1'b0; dout_ready = 1'b0;
        keep_one(100000);
        keep_one(-400000);
        step(2);
        chk("bp_dout_held", dout, 2343);
        chk("bp_valid", dout_valid, 1);
        chk("bp_overflow", overflow, 1);
        chk("bp_drop_cnt", drop_cnt, 1);
        chk("w3_shift", shift_out, 9);
        dout_ready = 1'b1;
        step(1);
        chk("bp_released", dout_valid, 0);

        // Accept and new code in the same cycle (1171 then 2171 with shift 9).
        dout_ready = 1'b0;
        keep_one(0);
        keep_one(512000);
        chk("acc_first", dout, 1171);
        chk("acc_first_valid", dout_valid, 1);
        dout_ready = 1'b1;
        step(1);
        chk("acc_new_dout", dout, 2171);
        chk("acc_new_valid", dout_valid, 1);
        chk("acc_no_drop", drop_cnt, 1);
        step(1);
        chk("acc_drained", dout_valid, 0);

        // 50% heart_valid: every 4th valid cycle is kept, idle-cycle data ignored.
        sb_on = 1'b1;
        vc = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                feed(((vc % 4) == 3) ? ((vc < 4) ? 100000 : -100000) : 7000000, 1'b1);
                vc++;
            end else begin
                feed(-7654321, 1'b0);
            end
        end
        step(3);
        chk("toggle_drain", q.size(), 0);

        // Reset mid-RUN with a pending code.
        sb_on = 1'b0; dout_ready = 1'b0;
        keep_one(0);
        step(1);
        chk("pre_reset_valid", dout_valid, 1);
        reset = 1'b1;
        step(1);
        chk_reset("mid_rst");
        reset = 1'b0; dout_ready = 1'b1;
        model_reset();
        sb_on = 1'b1;
        cal_window("w1b");
        keep_one(500);
        step(3);
        chk("final_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
